// File: rtl/tpu_pkg.sv
// tpu_pkg: opcodes, FSM encodings, command layout and clamp helper shared by the command executor
package tpu_pkg;
  localparam logic TRUE = 1'b1;
  localparam logic FALSE = 1'b0;
  localparam logic [7:0] TPU_CLEARSCREEN = 8'h01;
  localparam logic [7:0] TPU_PRINT = 8'h02;
  localparam logic [7:0] TPU_LOCATE = 8'h03;
  localparam logic [7:0] TPU_SETATTR = 8'h04;
  localparam logic [7:0] TPU_SETMASK = 8'h05;
  localparam logic [7:0] TPU_FILLAREA = 8'h06;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DECODE = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  typedef struct packed {
    logic [7:0] p3;
    logic [7:0] p2;
    logic [7:0] p1;
    logic [7:0] op;
  } cmd_t;
  function automatic logic [7:0] clamp(input logic [7:0] v, input int lim);
    return (int'({24'd0, v}) >= lim) ? 8'(lim - 1) : v;
  endfunction
endpackage

// File: rtl/tpu_command_executor_area_scan.sv
// tpu_area_scan: row-major rectangle walker producing the cell address and a last-cell flag
module tpu_area_scan #(
  parameter int COLS = 80,
  parameter int XW = 7,
  parameter int YW = 5,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_i,
  input  logic          step_i,
  input  logic [XW-1:0] x0_i,
  input  logic [XW-1:0] x1_i,
  input  logic [YW-1:0] y0_i,
  input  logic [YW-1:0] y1_i,
  output logic [AW-1:0] addr_o,
  output logic          last_o
);
  logic [XW-1:0] x_q, x0_q, x1_q;
  logic [YW-1:0] y_q, y1_q;
  logic [AW-1:0] base_q, addr_q;
  assign addr_o = addr_q;
  assign last_o = (x_q == x1_q) && (y_q == y1_q);
  // load the rectangle on start (constant-coefficient row base), then advance one cell per accepted write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q <= '0;
      x0_q <= '0;
      x1_q <= '0;
      y_q <= '0;
      y1_q <= '0;
      base_q <= '0;
      addr_q <= '0;
    end else if (start_i) begin
      x_q <= x0_i;
      x0_q <= x0_i;
      x1_q <= x1_i;
      y_q <= y0_i;
      y1_q <= y1_i;
      base_q <= AW'(32'(y0_i) * COLS);
      addr_q <= AW'(32'(y0_i) * COLS) + AW'(x0_i);
    end else if (step_i) begin
      if (x_q == x1_q) begin
        x_q <= x0_q;
        y_q <= y_q + 1'b1;
        base_q <= base_q + AW'(COLS);
        addr_q <= base_q + AW'(COLS) + AW'(x0_q);
      end else begin
        x_q <= x_q + 1'b1;
        addr_q <= addr_q + 1'b1;
      end
    end
  end
endmodule

// File: rtl/tpu_command_executor.sv
// tpu_command_executor: latches TPU commands, updates cursor/attr/mask state and issues masked text-memory writes
module tpu_command_executor
  import tpu_pkg::*;
#(
  parameter int COLS = 80,
  parameter int ROWS = 30,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  execute,
  input  logic [47:0]           command,
  output logic                  busy,
  output logic                  mem_write,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [23:0]           mem_data,
  output logic [23:0]           mem_mask
);
  localparam int XW = $clog2(COLS);
  localparam int YW = $clog2(ROWS);
  logic [1:0] state_q, state_d;
  cmd_t cmd_q, cmd_d;
  logic [XW-1:0] cx_q, cx_d, x_end, sx0, sx1;
  logic [YW-1:0] cy_q, cy_d, y_end, sy0, sy1;
  logic [7:0] attr1_q, attr1_d, attr2_q, attr2_d, mc_q, mc_d, m1_q, m1_d, m2_q, m2_d;
  logic wr_q, wr_d;
  logic [23:0] data_q, data_d, mask_q, mask_d;
  logic is_clr, is_prt, is_fill, writes, start, accept, last;
  assign is_clr = cmd_q.op == TPU_CLEARSCREEN;
  assign is_prt = cmd_q.op == TPU_PRINT;
  assign is_fill = cmd_q.op == TPU_FILLAREA;
  assign x_end = XW'(clamp(cmd_q.p1, COLS));
  assign y_end = YW'(clamp(cmd_q.p2, ROWS));
  assign writes = is_clr || is_prt || (is_fill && x_end >= cx_q && y_end >= cy_q);
  assign sx0 = is_clr ? '0 : cx_q;
  assign sy0 = is_clr ? '0 : cy_q;
  assign sx1 = is_clr ? XW'(COLS - 1) : is_fill ? x_end : cx_q;
  assign sy1 = is_clr ? YW'(ROWS - 1) : is_fill ? y_end : cy_q;
  assign start = (state_q == ST_DECODE) && writes;
  assign accept = wr_q && mem_ready;
  assign busy = (state_q != ST_IDLE) || execute;
  assign mem_write = wr_q;
  assign mem_data = data_q;
  assign mem_mask = mask_q;
  tpu_area_scan #(.COLS(COLS), .XW(XW), .YW(YW), .AW(ADDR_WIDTH)) u_scan (
    .clk(clk), .reset(reset), .start_i(start), .step_i(accept && !last),
    .x0_i(sx0), .x1_i(sx1), .y0_i(sy0), .y1_i(sy1),
    .addr_o(mem_address), .last_o(last)
  );
  // next-state: latch in IDLE, apply register updates and arm the first write in DECODE, retire writes in WRITE
  always_comb begin
    state_d = state_q;
    cmd_d = cmd_q;
    cx_d = cx_q;
    cy_d = cy_q;
    attr1_d = attr1_q;
    attr2_d = attr2_q;
    mc_d = mc_q;
    m1_d = m1_q;
    m2_d = m2_q;
    wr_d = wr_q;
    data_d = data_q;
    mask_d = mask_q;
    case (state_q)
      ST_DECODE: begin
        state_d = writes ? ST_WRITE : ST_IDLE;
        wr_d = writes;
        if (writes) begin
          data_d = {attr2_q, attr1_q, is_clr ? 8'h20 : is_prt ? cmd_q.p1 : cmd_q.p3};
          mask_d = is_clr ? 24'hFFFFFF : {m2_q, m1_q, mc_q};
        end
        if (is_clr) begin
          cx_d = '0;
          cy_d = '0;
        end
        if (is_prt) begin
          cx_d = (cx_q == XW'(COLS - 1)) ? '0 : cx_q + 1'b1;
          if (cx_q == XW'(COLS - 1)) cy_d = (cy_q == YW'(ROWS - 1)) ? '0 : cy_q + 1'b1;
        end
        if (cmd_q.op == TPU_LOCATE) begin
          cx_d = x_end;
          cy_d = y_end;
        end
        if (cmd_q.op == TPU_SETATTR) begin
          attr1_d = cmd_q.p1;
          attr2_d = cmd_q.p2;
        end
        if (cmd_q.op == TPU_SETMASK) begin
          mc_d = cmd_q.p1;
          m1_d = cmd_q.p2;
          m2_d = cmd_q.p3;
        end
      end
      ST_WRITE: begin
        if (accept && last) begin
          wr_d = FALSE;
          state_d = ST_IDLE;
        end
      end
      default: begin
        if (execute) begin
          cmd_d = command[31:0];
          state_d = ST_DECODE;
        end
      end
    endcase
  end
  // state registers with asynchronous reset to the documented power-on values
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cmd_q <= '0;
      cx_q <= '0;
      cy_q <= '0;
      attr1_q <= 8'h07;
      attr2_q <= 8'h00;
      mc_q <= 8'hFF;
      m1_q <= 8'hFF;
      m2_q <= 8'hFF;
      wr_q <= FALSE;
      data_q <= '0;
      mask_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q <= cmd_d;
      cx_q <= cx_d;
      cy_q <= cy_d;
      attr1_q <= attr1_d;
      attr2_q <= attr2_d;
      mc_q <= mc_d;
      m1_q <= m1_d;
      m2_q <= m2_d;
      wr_q <= wr_d;
      data_q <= data_d;
      mask_q <= mask_d;
    end
  end
endmodule

// File: tb/tb_tpu_command_executor.sv
// tb_tpu_command_executor: directed table, reset-abort sequence and random commands against a behavioural model
module tb_tpu_command_executor;
  localparam int COLS = 80;
  localparam int ROWS = 30;
  localparam int AW = 12;
  logic clk = 1'b0;
  logic reset, execute, mem_ready, busy, mem_write;
  logic [47:0] command;
  logic [AW-1:0] mem_address;
  logic [23:0] mem_data, mem_mask;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  tpu_command_executor #(.COLS(COLS), .ROWS(ROWS), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .execute(execute), .command(command), .busy(busy),
    .mem_write(mem_write), .mem_ready(mem_ready), .mem_address(mem_address),
    .mem_data(mem_data), .mem_mask(mem_mask)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  typedef struct {
    logic [AW-1:0] a;
    logic [23:0] d;
    logic [23:0] m;
  } wr_t;
  wr_t exp_q[$];
  int cx, cy;
  logic [7:0] a1, a2, mc, m1, m2;
  task automatic model_reset();
    cx = 0;
    cy = 0;
    a1 = 8'h07;
    a2 = 8'h00;
    mc = 8'hFF;
    m1 = 8'hFF;
    m2 = 8'hFF;
    exp_q.delete();
  endtask
  task automatic push(input int x, input int y, input logic [7:0] ch, input logic [23:0] m);
    wr_t w;
    w.a = AW'(y * COLS + x);
    w.d = {a2, a1, ch};
    w.m = m;
    exp_q.push_back(w);
  endtask
  task automatic model_cmd(input logic [7:0] op, input logic [7:0] p1, input logic [7:0] p2, input logic [7:0] p3);
    int xe, ye;
    xe = (int'(p1) >= COLS) ? COLS - 1 : int'(p1);
    ye = (int'(p2) >= ROWS) ? ROWS - 1 : int'(p2);
    case (op)
      8'h01: begin
        for (int y = 0; y < ROWS; y++) for (int x = 0; x < COLS; x++) push(x, y, 8'h20, 24'hFFFFFF);
        cx = 0;
        cy = 0;
      end
      8'h02: begin
        push(cx, cy, p1, {m2, m1, mc});
        cx++;
        if (cx == COLS) begin
          cx = 0;
          cy = (cy + 1) % ROWS;
        end
      end
      8'h03: begin
        cx = xe;
        cy = ye;
      end
      8'h04: begin
        a1 = p1;
        a2 = p2;
      end
      8'h05: begin
        mc = p1;
        m1 = p2;
        m2 = p3;
      end
      8'h06: for (int y = cy; y <= ye; y++) for (int x = cx; x <= xe; x++) push(x, y, p3, {m2, m1, mc});
      default: ;
    endcase
  endtask
  task automatic run_cmd(input logic [7:0] op, input logic [7:0] p1, input logic [7:0] p2, input logic [7:0] p3,
                         input int mode, input int abort_after, output int nw,
                         output logic [31:0] fa, output logic [31:0] fd, output logic [31:0] fm);
    bit tog;
    wr_t w;
    model_cmd(op, p1, p2, p3);
    nw = 0;
    fa = 0;
    fd = 0;
    fm = 0;
    tog = 1'b1;
    @(negedge clk);
    execute = 1'b1;
    command = {16'($urandom), p3, p2, p1, op};
    #1 chk("busy_pulse", busy, 1);
    @(negedge clk);
    execute = 1'b0;
    #1 chk("busy_decode", busy, 1);
    chk("wr_decode", mem_write, 0);
    for (int c = 0; ; c++) begin
      @(negedge clk);
      if (c > 10000) begin
        chk("timeout", 1, 0);
        break;
      end
      if (exp_q.size() == 0) begin
        chk("idle_busy", busy, 0);
        chk("idle_wr", mem_write, 0);
        break;
      end
      w = exp_q[0];
      chk("wr_busy", busy, 1);
      chk("wr_valid", mem_write, 1);
      chk("wr_addr", mem_address, w.a);
      chk("wr_data", mem_data, w.d);
      chk("wr_mask", mem_mask, w.m);
      if (nw == 0) begin
        fa = 32'(mem_address);
        fd = 32'(mem_data);
        fm = 32'(mem_mask);
      end
      mem_ready = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
      tog = ~tog;
      if (mem_ready) begin
        void'(exp_q.pop_front());
        nw++;
        if (abort_after >= 0 && nw == abort_after) return;
      end
    end
  endtask
  typedef struct {
    logic [7:0] op, p1, p2, p3;
    int mode;
    int nw;
    logic [31:0] fa, fd, fm;
  } vec_t;
  vec_t tbl[15];
  initial begin
    int nw;
    logic [31:0] fa, fd, fm;
    logic [7:0] op;
    tbl[0] = '{8'h04, 8'h1E, 8'h40, 8'h00, 0, 0, 0, 0, 0};
    tbl[1] = '{8'h02, 8'h41, 8'h00, 8'h00, 0, 1, 0, 32'h401E41, 32'hFFFFFF};
    tbl[2] = '{8'h02, 8'h42, 8'h00, 8'h00, 0, 1, 1, 32'h401E42, 32'hFFFFFF};
    tbl[3] = '{8'h03, 8'd79, 8'd29, 8'h00, 0, 0, 0, 0, 0};
    tbl[4] = '{8'h02, 8'h43, 8'h00, 8'h00, 0, 1, 2399, 32'h401E43, 32'hFFFFFF};
    tbl[5] = '{8'h02, 8'h44, 8'h00, 8'h00, 0, 1, 0, 32'h401E44, 32'hFFFFFF};
    tbl[6] = '{8'h02, 8'h45, 8'h00, 8'h00, 0, 1, 1, 32'h401E45, 32'hFFFFFF};
    tbl[7] = '{8'h03, 8'd200, 8'd200, 8'h00, 0, 0, 0, 0, 0};
    tbl[8] = '{8'h02, 8'h46, 8'h00, 8'h00, 0, 1, 2399, 32'h401E46, 32'hFFFFFF};
    tbl[9] = '{8'h05, 8'h0F, 8'h00, 8'hFF, 0, 0, 0, 0, 0};
    tbl[10] = '{8'h03, 8'd2, 8'd3, 8'h00, 0, 0, 0, 0, 0};
    tbl[11] = '{8'h06, 8'd4, 8'd4, 8'h2A, 1, 6, 242, 32'h401E2A, 32'hFF000F};
    tbl[12] = '{8'h02, 8'h47, 8'h00, 8'h00, 2, 1, 242, 32'h401E47, 32'hFF000F};
    tbl[13] = '{8'h06, 8'd1, 8'd9, 8'h2B, 0, 0, 0, 0, 0};
    tbl[14] = '{8'h06, 8'd10, 8'd2, 8'h2B, 0, 0, 0, 0, 0};
    reset = 1'b1;
    execute = 1'b0;
    mem_ready = 1'b1;
    command = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_wr", mem_write, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_data", mem_data, 0);
    chk("rst_mask", mem_mask, 0);
    reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      run_cmd(tbl[i].op, tbl[i].p1, tbl[i].p2, tbl[i].p3, tbl[i].mode, -1, nw, fa, fd, fm);
      chk($sformatf("tbl%0d_count", i), nw, tbl[i].nw);
      if (tbl[i].nw > 0) begin
        chk($sformatf("tbl%0d_addr", i), fa, tbl[i].fa);
        chk($sformatf("tbl%0d_data", i), fd, tbl[i].fd);
        chk($sformatf("tbl%0d_mask", i), fm, tbl[i].fm);
      end
    end
    run_cmd(8'h01, 8'h00, 8'h00, 8'h00, 0, 100, nw, fa, fd, fm);
    chk("clr_count", nw, 100);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 chk("abort_wr", mem_write, 0);
    chk("abort_busy", busy, 0);
    chk("abort_addr", mem_address, 0);
    chk("abort_data", mem_data, 0);
    chk("abort_mask", mem_mask, 0);
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b1;
    model_reset();
    run_cmd(8'h02, 8'h41, 8'h00, 8'h00, 0, -1, nw, fa, fd, fm);
    chk("post_rst_count", nw, 1);
    chk("post_rst_addr", fa, 0);
    chk("post_rst_data", fd, 32'h000741);
    chk("post_rst_mask", fm, 32'hFFFFFF);
    for (int i = 0; i < 80; i++) begin
      op = 8'($urandom_range(0, 7));
      if (op == 8'h01 && $urandom_range(0, 9) != 0) op = 8'h02;
      run_cmd(op, 8'($urandom_range(0, 100)), 8'($urandom_range(0, 40)), 8'($urandom),
              int'($urandom_range(0, 2)), -1, nw, fa, fd, fm);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
